right_shifter: RTL and testbench
================================

Name: right_shifter

Overview:
- Parameterised logarithmic barrel shifter performing a logical right shift of data word `a` by amount `b`.
- Sits in the datapath shift unit, alongside the ALU.
- Result is registered: one clock of latency, with a valid flag travelling alongside the data.
- Optional build-time arithmetic (sign-fill) mode.

Parameters:
- width, 16, data width in bits; must be a power of two and >= 2.
- l (localparam, not overridable), $clog2(width), shift-amount width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  `a`/`b` are valid this cycle.
- a  input  width  data to shift.
- b  input  l  shift amount, 0..width-1, unsigned.
- out_valid  output  1  `y` holds a result.
- y  output  width  shifted result.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of `clk`.
  - Reset is synchronous and active-high.
  - While `rst`=1 at a clock edge: `y` <= 0 and `out_valid` <= 0.
  - Reset has priority over `in_valid`. A transaction presented in the same cycle as reset is dropped.
- Function:
  - Logical mode: `y` = `a` >> `b`.
  - Vacated MSBs are filled with 0.
  - `b`=0 passes `a` unchanged.
  - `b`=width-1 leaves only `a[width-1]` in bit 0.
- Structure:
  - Combinational network of l stages.
  - Stage k shifts right by 2^k when `b[k]`=1, otherwise passes its input through.
  - Final stage output is captured in the `y` register.
  - No `>>` operator on a variable amount; stages are explicit muxes, generated with a generate loop over k.
- Latency and valid:
  - Exactly 1 cycle: inputs sampled at edge N appear on `y` after edge N.
  - `out_valid` after edge N equals `in_valid` sampled at edge N.
- Hold behaviour:
  - When `in_valid`=0 at an edge, `y` holds its previous value; `out_valid` goes 0.
  - No backpressure: a new result can be accepted every cycle, i.e. full throughput.
- Out-of-range amounts: none are possible, since `b` is l bits wide and its maximum is width-1.
- No internal state other than `y` and `out_valid`.

Optional Feature:
- Macro: RIGHT_SHIFTER_ARITH_EN.
- When defined:
  - Adds input port `arith` (1 bit), sampled with `a`/`b`.
  - `arith`=1: vacated MSBs are filled with `a[width-1]` (arithmetic shift).
  - `arith`=0: zero fill, as in logical mode.
  - Fill is applied per stage using the original sign bit.
- When undefined:
  - No `arith` port.
  - Always logical shift; identical to `arith`=0 behaviour.

Test Plan (width=16):
- Reset: `rst`=1 for 2 edges with `in_valid`=1, `a`=FFFF -> `y`=0000, `out_valid`=0; input dropped.
- Sweep: `a`=FFFF, `b`=0..F, one per cycle, `in_valid`=1 -> one cycle later `y` follows FFFF >> b (`b`=0 -> FFFF, `b`=1 -> 7FFF, `b`=4 -> 0FFF, `b`=8 -> 00FF, `b`=F -> 0001), `out_valid`=1 each cycle.
- Pattern: `a`=8001, `b`=F -> 0001; `a`=1234, `b`=4 -> 0123; `a`=A5A5, `b`=3 -> 14B4; `a`=0000, any `b` -> 0000.
- Hold: result 0123 captured, then `in_valid`=0 with `a`=FFFF, `b`=0 -> `y` stays 0123, `out_valid`=0.
- Back-to-back: alternating `b`=0/`b`=F on `a`=FFFF for 8 cycles -> `y` alternates FFFF/0001 with 1-cycle lag, no bubbles.
- RIGHT_SHIFTER_ARITH_EN build: `a`=8000, `b`=F, `arith`=1 -> FFFF; same with `arith`=0 -> 0001; `a`=7FFF, `b`=4, `arith`=1 -> 07FF.

Source files
------------

// File: rtl/right_shifter.sv
// Purpose : logarithmic barrel shifter, y = a >> b (logical; sign-fill when RIGHT_SHIFTER_ARITH_EN is defined and arith=1).
// Latency : 1 cycle, registered result with out_valid travelling alongside.
// Backpres: none, accepts a new operand pair every cycle; y holds when in_valid=0.
module right_shifter #(
    parameter int  width = 16,
    localparam int l     = $clog2(width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [width-1:0] a,
    input  logic [l-1:0]     b,
`ifdef RIGHT_SHIFTER_ARITH_EN
    input  logic             arith,
`endif
    output logic             out_valid,
    output logic [width-1:0] y
);

    // Shift network only works for power-of-two widths of at least 2.
    if (width < 2 || (width & (width - 1)) != 0) begin : g_bad_width
        $error("right_shifter: width must be a power of two and >= 2");
    end

    // Bit shifted into vacated MSBs. Every stage uses the original sign of a,
    // so the fill stays correct no matter which stages are bypassed.
    logic fill_bit;
`ifdef RIGHT_SHIFTER_ARITH_EN
    assign fill_bit = arith & a[width-1];
`else
    assign fill_bit = 1'b0;
`endif

    // Stage k shifts right by 2^k when b[k] is set, otherwise passes through.
    for (genvar k = 0; k < l; k++) begin : g_stage
        localparam int SH = 2 ** k;
        logic [width-1:0] s_in;
        logic [width-1:0] s_out;

        if (k == 0) begin : g_first
            assign s_in = a;
        end else begin : g_next
            assign s_in = g_stage[k-1].s_out;
        end

        assign s_out = b[k] ? {{SH{fill_bit}}, s_in[width-1:SH]} : s_in;
    end

    logic [width-1:0] shift_dat;
    assign shift_dat = g_stage[l-1].s_out;

    logic [width-1:0] y_d;
    logic [width-1:0] y_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Capture a new result on valid input; otherwise keep the last one.
    always_comb begin
        y_d         = y_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            y_d = shift_dat;
        end
    end

    // Result and valid registers; reset wins over an incoming transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_right_shifter.sv
// Testbench for right_shifter (width=16): directed plan plus randomized traffic
// checked against a behavioural shift model. Covers RIGHT_SHIFTER_ARITH_EN builds too.
module tb_right_shifter;

    localparam int W = 16;

`ifdef RIGHT_SHIFTER_ARITH_EN
    localparam bit ARITH_BUILD = 1'b1;
`else
    localparam bit ARITH_BUILD = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [3:0]   b;
    logic         arith_i;
    logic         out_valid;
    logic [W-1:0] y;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: what y / out_valid should hold after the latest edge.
    logic [W-1:0] mdl_y;
    logic         mdl_v;

    right_shifter #(.width(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef RIGHT_SHIFTER_ARITH_EN
        .arith     (arith_i),
`endif
        .out_valid (out_valid),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Shift by plain arithmetic: logical shift, then OR in ones over the vacated MSBs for sign fill.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] av, input logic [3:0] bv,
                                               input logic ar);
        logic [W-1:0] r;
        logic [W-1:0] ones;
        ones = '1;
        r = av >> bv;
        if (ARITH_BUILD && ar && av[W-1]) r = r | ~(ones >> bv);
        return r;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, then compare just after it.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] av,
                        input logic [3:0] bv, input logic ar);
        rst      = r;
        in_valid = iv;
        a        = av;
        b        = bv;
        arith_i  = ar;
        @(posedge clk);
        if (r) begin
            mdl_y = '0;
            mdl_v = 1'b0;
        end else begin
            mdl_v = iv;
            if (iv) mdl_y = ref_shift(av, bv, ar);
        end
        #1;
        check("y", {16'h0, y}, {16'h0, mdl_y});
        check("out_valid", {31'h0, out_valid}, {31'h0, mdl_v});
    endtask

    logic [W-1:0] pat_a   [4] = '{16'h8001, 16'h1234, 16'hA5A5, 16'h0000};
    logic [3:0]   pat_b   [4] = '{4'hF, 4'h4, 4'h3, 4'h7};
    logic [W-1:0] pat_exp [4] = '{16'h0001, 16'h0123, 16'h14B4, 16'h0000};

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; arith_i = 1'b0;
        mdl_y = '0; mdl_v = 1'b0;
        #1;

        // Reset with a valid transaction presented: must be dropped.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 16'hFFFF, 4'h0, 1'b0);
            check("rst_y", {16'h0, y}, 32'h0);
            check("rst_vld", {31'h0, out_valid}, 32'h0);
        end

        // Sweep all shift amounts on all-ones.
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ones;
            ones = '1;
            step(1'b0, 1'b1, 16'hFFFF, 4'(i), 1'b0);
            check("sweep", {16'h0, y}, {16'h0, ones >> i});
        end

        // Directed patterns with hand-computed results.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, pat_a[i], pat_b[i], 1'b0);
            check("pattern", {16'h0, y}, {16'h0, pat_exp[i]});
        end

        // Hold: capture 0123, then an invalid cycle must not disturb y.
        step(1'b0, 1'b1, 16'h1234, 4'h4, 1'b0);
        check("hold_cap", {16'h0, y}, 32'h0123);
        step(1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b0);
        check("hold_y", {16'h0, y}, 32'h0123);
        check("hold_vld", {31'h0, out_valid}, 32'h0);

        // Back-to-back alternating amounts, no bubbles.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 16'hFFFF, (i % 2 == 0) ? 4'h0 : 4'hF, 1'b0);
            check("b2b", {16'h0, y}, (i % 2 == 0) ? 32'hFFFF : 32'h0001);
            check("b2b_vld", {31'h0, out_valid}, 32'h1);
        end

`ifdef RIGHT_SHIFTER_ARITH_EN
        step(1'b0, 1'b1, 16'h8000, 4'hF, 1'b1);
        check("arith_neg", {16'h0, y}, 32'hFFFF);
        step(1'b0, 1'b1, 16'h8000, 4'hF, 1'b0);
        check("arith_off", {16'h0, y}, 32'h0001);
        step(1'b0, 1'b1, 16'h7FFF, 4'h4, 1'b1);
        check("arith_pos", {16'h0, y}, 32'h07FF);
`endif

        // Randomized traffic with sporadic invalid cycles and resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 W'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
